// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC register and IF/ID pipeline register; branch redirect from ID.
// Latency: word accepted on edge N appears on if_id_instruction after edge N; branch costs one bubble.
// Backpressure: stall holds PC and IF/ID and drops imem_req; imem_ready low inserts NOP bubbles.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic [31:0] branch_pc,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_instruction,
    output logic [31:0] id_pc,
    output logic        id_valid
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] branch_target;

    // Shift drops offset[31:30]; modular add makes negative offsets subtract.
    assign branch_target = (branch_pc + 32'd8 + {branch_offset[29:0], 2'b00}) & 32'hFFFF_FFFC;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stall) begin
                    pc_d = pc_q;
                end else if (branch_taken) begin
                    pc_d       = branch_target;
                    instr_d    = NOP_INSTR;
                    id_valid_d = 1'b0;
                end else if (imem_ready) begin
                    pc_d       = pc_q + 32'd4;
                    instr_d    = imem_data;
                    id_pc_d    = pc_q;
                    id_valid_d = 1'b1;
                end else begin
                    instr_d    = NOP_INSTR;
                    id_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            id_pc_q    <= 32'd0;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign imem_req          = (state_q == ST_RUN) && !stall;
    assign imem_addr         = pc_q;
    assign if_id_instruction = instr_q;
    assign id_pc             = id_pc_q;
    assign id_valid          = id_valid_q;

endmodule
